// File: rtl/ddr_rd_arb_if.sv
// Bundle of requester, DDR read-engine and status signals
// around the three-port DDR read arbiter.
interface ddr_rd_arb_if;
   logic        rq0_req;
   logic        rq1_req;
   logic        rq2_req;
   logic        rq0_ack;
   logic        rq1_ack;
   logic        rq2_ack;
   logic        rq0_vout;
   logic        rq1_vout;
   logic        rq2_vout;
   logic [31:0] rq0_dout;
   logic [31:0] rq1_dout;
   logic [31:0] rq2_dout;
   logic        rq0_vin;
   logic        rq1_vin;
   logic        rq2_vin;
   logic [31:0] rq0_din;
   logic [31:0] rq1_din;
   logic [31:0] rq2_din;
   logic        ddr_cmd_v;
   logic [31:0] ddr_cmd_d;
   logic        ddr_rd_v;
   logic [31:0] ddr_rd_d;
   logic        busy;
   logic [1:0]  gnt_id;
   logic        err;

   modport slave (
      input  rq0_req, rq1_req, rq2_req,
      input  rq0_vout, rq1_vout, rq2_vout,
      input  rq0_dout, rq1_dout, rq2_dout,
      input  ddr_rd_v, ddr_rd_d,
      output rq0_ack, rq1_ack, rq2_ack,
      output rq0_vin, rq1_vin, rq2_vin,
      output rq0_din, rq1_din, rq2_din,
      output ddr_cmd_v, ddr_cmd_d,
      output busy, gnt_id, err
   );

   modport master (
      output rq0_req, rq1_req, rq2_req,
      output rq0_vout, rq1_vout, rq2_vout,
      output rq0_dout, rq1_dout, rq2_dout,
      output ddr_rd_v, ddr_rd_d,
      input  rq0_ack, rq1_ack, rq2_ack,
      input  rq0_vin, rq1_vin, rq2_vin,
      input  rq0_din, rq1_din, rq2_din,
      input  ddr_cmd_v, ddr_cmd_d,
      input  busy, gnt_id, err
   );
endinterface

// File: rtl/ddr_rd_arb.sv
// Round-robin arbiter sharing one DDR read engine between
// three requesters: command forwarding and read-data routing.
module ddr_rd_arb #(
   parameter int LEN_W = 16,
   parameter int NREQ  = 3
) (
   input logic         clk,
   input logic         rst_n,
   ddr_rd_arb_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      DATA,
      RELEASE
   } state_t;

   state_t state, state_nxt;

   logic [2:0]       req;
   logic [2:0]       vout;
   logic [31:0]      dout [NREQ];
   logic [1:0]       rr_ptr;
   logic [1:0]       p1, p2;
   logic [1:0]       sel;
   logic             sel_v;
   logic [1:0]       gnt, gnt_nxt;
   logic             wcnt;
   logic [LEN_W-1:0] len, cnt, cnt_inc;
   logic             accept;
   logic [31:0]      cur_word;
   logic [LEN_W-1:0] len_w;
   logic [2:0]       ack, ack_nxt;
   logic [2:0]       vin;
   logic [31:0]      din [NREQ];
   logic             cmd_v;
   logic [31:0]      cmd_d;
   logic             err_q;

   function automatic logic [1:0] inc3(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   assign req  = {bus.rq2_req, bus.rq1_req, bus.rq0_req};
   assign vout = {bus.rq2_vout, bus.rq1_vout, bus.rq0_vout};
   assign dout[0] = bus.rq0_dout;
   assign dout[1] = bus.rq1_dout;
   assign dout[2] = bus.rq2_dout;

   always_comb begin
      p1    = inc3(rr_ptr);
      p2    = inc3(p1);
      sel   = rr_ptr;
      sel_v = 1'b1;
      if (req[rr_ptr])  sel = rr_ptr;
      else if (req[p1]) sel = p1;
      else if (req[p2]) sel = p2;
      else              sel_v = 1'b0;
   end

   assign accept   = (state == GRANT) && vout[gnt];
   assign cur_word = dout[gnt];
   assign len_w    = cur_word[LEN_W-1:0];
   assign cnt_inc  = cnt + LEN_W'(1);

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      ack_nxt   = '0;
      unique case (state)
         IDLE: begin
            if (sel_v) begin
               state_nxt = GRANT;
               gnt_nxt   = sel;
            end
         end
         GRANT: begin
            if (accept && wcnt)
               state_nxt = (len_w == '0) ? RELEASE : DATA;
         end
         DATA: begin
            if (bus.ddr_rd_v && cnt_inc == len)
               state_nxt = RELEASE;
         end
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // ack is a registered copy of the next-state grant
      if (state_nxt == GRANT || state_nxt == DATA)
         ack_nxt[gnt_nxt] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         rr_ptr <= 2'd0;
         gnt    <= 2'd0;
         wcnt   <= 1'b0;
         len    <= '0;
         cnt    <= '0;
         ack    <= '0;
         vin    <= '0;
         cmd_v  <= 1'b0;
         cmd_d  <= '0;
         err_q  <= 1'b0;
         for (int i = 0; i < NREQ; i++)
            din[i] <= '0;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         ack   <= ack_nxt;
         cmd_v <= accept;
         vin   <= '0;
         err_q <= bus.ddr_rd_v && (state != DATA);
         if (state == IDLE && sel_v) begin
            wcnt <= 1'b0;
            cnt  <= '0;
         end
         if (accept) begin
            cmd_d <= cur_word;
            wcnt  <= 1'b1;
            if (wcnt)
               len <= len_w;
         end
         if (state == DATA && bus.ddr_rd_v) begin
            vin[gnt] <= 1'b1;
            din[gnt] <= bus.ddr_rd_d;
            cnt      <= cnt_inc;
         end
         if (state == RELEASE)
            rr_ptr <= inc3(gnt);
      end
   end

   assign bus.rq0_ack   = ack[0];
   assign bus.rq1_ack   = ack[1];
   assign bus.rq2_ack   = ack[2];
   assign bus.rq0_vin   = vin[0];
   assign bus.rq1_vin   = vin[1];
   assign bus.rq2_vin   = vin[2];
   assign bus.rq0_din   = din[0];
   assign bus.rq1_din   = din[1];
   assign bus.rq2_din   = din[2];
   assign bus.ddr_cmd_v = cmd_v;
   assign bus.ddr_cmd_d = cmd_d;
   assign bus.busy      = (state != IDLE);
   assign bus.gnt_id    = gnt;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_ddr_rd_arb.sv
// Directed bench for ddr_rd_arb: grant order, command
// forwarding, data routing, dropped beats and async reset.
module tb_ddr_rd_arb;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   ddr_rd_arb_if bus ();

   ddr_rd_arb #(.LEN_W(16), .NREQ(3)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   logic [2:0] acks, vins;
   assign acks = {bus.rq2_ack, bus.rq1_ack, bus.rq0_ack};
   assign vins = {bus.rq2_vin, bus.rq1_vin, bus.rq0_vin};

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_vout(input int id, input logic v,
                           input logic [31:0] d);
      case (id)
         0: begin bus.rq0_vout = v; bus.rq0_dout = d; end
         1: begin bus.rq1_vout = v; bus.rq1_dout = d; end
         default: begin bus.rq2_vout = v; bus.rq2_dout = d; end
      endcase
   endtask

   function automatic logic [31:0] din_of(input int id);
      case (id)
         0: return bus.rq0_din;
         1: return bus.rq1_din;
         default: return bus.rq2_din;
      endcase
   endfunction

   // one-beat transaction by the expected grantee
   task automatic serve(input int id);
      logic [2:0] oh;
      oh = 3'b001 << id;
      for (int i = 0; i < 6 && acks == 3'b000; i++)
         tick();
      chk("serve_ack", {29'd0, acks}, {29'd0, oh});
      chk("serve_gnt", {30'd0, bus.gnt_id}, id);
      set_vout(id, 1'b1, 32'h5000_0000 + id);
      tick();
      chk("serve_ack1", {29'd0, acks}, {29'd0, oh});
      set_vout(id, 1'b1, 32'd1);
      tick();
      chk("serve_ack2", {29'd0, acks}, {29'd0, oh});
      set_vout(id, 1'b0, 32'd0);
      bus.ddr_rd_v = 1'b1;
      bus.ddr_rd_d = 32'hB0 + id;
      tick();
      bus.ddr_rd_v = 1'b0;
      chk("serve_vin", {29'd0, vins}, {29'd0, oh});
      chk("serve_din", din_of(id), 32'hB0 + id);
      chk("serve_rel_ack", {29'd0, acks}, 32'd0);
      tick();
      chk("serve_idle", {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      bus.rq0_req = 0; bus.rq1_req = 0; bus.rq2_req = 0;
      bus.rq0_vout = 0; bus.rq1_vout = 0; bus.rq2_vout = 0;
      bus.rq0_dout = 0; bus.rq1_dout = 0; bus.rq2_dout = 0;
      bus.ddr_rd_v = 0; bus.ddr_rd_d = 0;

      // reset state
      tick();
      tick();
      chk("rst_ack", {29'd0, acks}, 32'd0);
      chk("rst_vin", {29'd0, vins}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_gnt", {30'd0, bus.gnt_id}, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      chk("rst_cmd_v", {31'd0, bus.ddr_cmd_v}, 32'd0);
      chk("rst_cmd_d", bus.ddr_cmd_d, 32'd0);
      chk("rst_din1", bus.rq1_din, 32'd0);
      rst_n = 1'b1;

      // all three requesting: order 0,1,2,0
      bus.rq0_req = 1; bus.rq1_req = 1; bus.rq2_req = 1;
      serve(0);
      serve(1);
      serve(2);
      serve(0);
      bus.rq0_req = 0; bus.rq1_req = 0; bus.rq2_req = 0;

      // single request from rq1, 4 beats, extra word ignored
      bus.rq1_req = 1;
      tick();
      chk("t1_ack", {29'd0, acks}, 32'b010);
      chk("t1_gnt", {30'd0, bus.gnt_id}, 32'd1);
      chk("t1_cmd_v0", {31'd0, bus.ddr_cmd_v}, 32'd0);
      bus.rq1_req = 0;
      set_vout(1, 1'b1, 32'h1000_0000);
      tick();
      chk("t1_cmd_v1", {31'd0, bus.ddr_cmd_v}, 32'd1);
      chk("t1_cmd_d1", bus.ddr_cmd_d, 32'h1000_0000);
      set_vout(1, 1'b1, 32'h0000_0004);
      tick();
      chk("t1_cmd_v2", {31'd0, bus.ddr_cmd_v}, 32'd1);
      chk("t1_cmd_d2", bus.ddr_cmd_d, 32'h0000_0004);
      set_vout(1, 1'b1, 32'hDEAD_BEEF);
      bus.ddr_rd_v = 1'b1;
      bus.ddr_rd_d = 32'hA0;
      tick();
      set_vout(1, 1'b0, 32'd0);
      chk("t1_cmd_v3", {31'd0, bus.ddr_cmd_v}, 32'd0);
      chk("t1_cmd_d3", bus.ddr_cmd_d, 32'h0000_0004);
      for (int i = 1; i < 4; i++) begin
         chk("t1_vin", {29'd0, vins}, 32'b010);
         chk("t1_din", bus.rq1_din, 32'hA0 + i - 1);
         chk("t1_ack_d", {29'd0, acks}, 32'b010);
         bus.ddr_rd_d = 32'hA0 + i;
         tick();
      end
      bus.ddr_rd_v = 1'b0;
      chk("t1_vin4", {29'd0, vins}, 32'b010);
      chk("t1_din4", bus.rq1_din, 32'hA3);
      chk("t1_rel_ack", {29'd0, acks}, 32'd0);
      chk("t1_rel_busy", {31'd0, bus.busy}, 32'd1);
      chk("t1_rel_gnt", {30'd0, bus.gnt_id}, 32'd1);
      tick();
      chk("t1_idle", {31'd0, bus.busy}, 32'd0);
      chk("t1_vin_off", {29'd0, vins}, 32'd0);
      chk("t1_gnt_hold", {30'd0, bus.gnt_id}, 32'd1);
      chk("t1_err", {31'd0, bus.err}, 32'd0);

      // stray beat in IDLE
      bus.ddr_rd_v = 1'b1;
      bus.ddr_rd_d = 32'h77;
      tick();
      bus.ddr_rd_v = 1'b0;
      chk("idle_err", {31'd0, bus.err}, 32'd1);
      chk("idle_vin", {29'd0, vins}, 32'd0);
      tick();
      chk("idle_err_off", {31'd0, bus.err}, 32'd0);

      // length 0 from rq0 (rr_ptr=2 -> 0 granted)
      bus.rq0_req = 1;
      tick();
      bus.rq0_req = 0;
      chk("l0_ack", {29'd0, acks}, 32'b001);
      chk("l0_gnt", {30'd0, bus.gnt_id}, 32'd0);
      chk("l0_busy1", {31'd0, bus.busy}, 32'd1);
      set_vout(0, 1'b1, 32'h2000_0000);
      tick();
      chk("l0_busy2", {31'd0, bus.busy}, 32'd1);
      set_vout(0, 1'b1, 32'h0000_0000);
      tick();
      set_vout(0, 1'b0, 32'd0);
      chk("l0_busy3", {31'd0, bus.busy}, 32'd1);
      chk("l0_rel_ack", {29'd0, acks}, 32'd0);
      chk("l0_cmd_d", bus.ddr_cmd_d, 32'd0);
      tick();
      chk("l0_busy4", {31'd0, bus.busy}, 32'd0);
      chk("l0_vin", {29'd0, vins}, 32'd0);

      // rq2 vout while rq0 granted (rr_ptr=1 -> 0 granted)
      bus.rq0_req = 1;
      tick();
      bus.rq0_req = 0;
      chk("x_ack", {29'd0, acks}, 32'b001);
      set_vout(0, 1'b1, 32'h3000_0000);
      set_vout(2, 1'b1, 32'hBAD0_0002);
      tick();
      chk("x_cmd_d1", bus.ddr_cmd_d, 32'h3000_0000);
      set_vout(0, 1'b1, 32'h0000_0002);
      tick();
      chk("x_cmd_d2", bus.ddr_cmd_d, 32'h0000_0002);
      set_vout(0, 1'b0, 32'd0);
      tick();
      chk("x_cmd_v3", {31'd0, bus.ddr_cmd_v}, 32'd0);
      set_vout(2, 1'b0, 32'd0);
      bus.ddr_rd_v = 1'b1;
      bus.ddr_rd_d = 32'hC0;
      tick();
      chk("x_vin0", {29'd0, vins}, 32'b001);
      bus.ddr_rd_d = 32'hC1;
      tick();
      bus.ddr_rd_v = 1'b0;
      chk("x_vin1", {29'd0, vins}, 32'b001);
      chk("x_din", bus.rq0_din, 32'hC1);
      chk("x_din2", bus.rq2_din, 32'hB2);
      tick();

      // reset in DATA after 2 of 8 beats (rr_ptr=1 -> 2)
      bus.rq2_req = 1;
      tick();
      bus.rq2_req = 0;
      chk("r_ack", {29'd0, acks}, 32'b100);
      set_vout(2, 1'b1, 32'h4000_0000);
      tick();
      set_vout(2, 1'b1, 32'h0000_0008);
      tick();
      set_vout(2, 1'b0, 32'd0);
      bus.ddr_rd_v = 1'b1;
      bus.ddr_rd_d = 32'hD0;
      tick();
      bus.ddr_rd_d = 32'hD1;
      tick();
      chk("r_vin", {29'd0, vins}, 32'b100);
      chk("r_din", bus.rq2_din, 32'hD1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("r_ack0", {29'd0, acks}, 32'd0);
      chk("r_vin0", {29'd0, vins}, 32'd0);
      chk("r_din0", bus.rq2_din, 32'd0);
      chk("r_busy0", {31'd0, bus.busy}, 32'd0);
      chk("r_gnt0", {30'd0, bus.gnt_id}, 32'd0);
      chk("r_cmd0", {31'd0, bus.ddr_cmd_v}, 32'd0);
      chk("r_cmdd0", bus.ddr_cmd_d, 32'd0);
      chk("r_err0", {31'd0, bus.err}, 32'd0);
      bus.ddr_rd_v = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.rq1_req = 1;
      serve(1);
      bus.rq1_req = 0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
